pmem_arbiter: RTL
=================

Name: pmem_arbiter

Overview:
- Arbitrates between the instruction cache miss port and the data cache miss/writeback port for the single shared physical-memory line port of the pipelined LC-3b.
- Sits between the two L1 cache controllers and pmem / L2.
- Grants one requester at a time, holds the granted request stable until pmem_resp, and routes the response back to that requester.
- Data side has priority; a starvation limit guarantees instruction fetch forward progress.

Parameters:
- ADDR_WIDTH, 16, byte address width.
- LINE_WIDTH, 128, cache line width in bits.
- STARVE_LIMIT, 4, consecutive D grants allowed while I is waiting before I is forced (range 1-15).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- i_pmem_read  in  1  I-cache line read request.
- i_pmem_address  in  ADDR_WIDTH  I-cache line address.
- i_pmem_rdata  out  LINE_WIDTH  read line to I-cache.
- i_pmem_resp  out  1  I-cache transaction complete.
- d_pmem_read  in  1  D-cache line read request.
- d_pmem_write  in  1  D-cache line writeback request.
- d_pmem_address  in  ADDR_WIDTH  D-cache line address.
- d_pmem_wdata  in  LINE_WIDTH  D-cache writeback line.
- d_pmem_rdata  out  LINE_WIDTH  read line to D-cache.
- d_pmem_resp  out  1  D-cache transaction complete.
- pmem_read  out  1  memory read strobe.
- pmem_write  out  1  memory write strobe.
- pmem_address  out  ADDR_WIDTH  memory address.
- pmem_wdata  out  LINE_WIDTH  memory write line.
- pmem_rdata  in  LINE_WIDTH  memory read line.
- pmem_resp  in  1  memory transaction complete.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values:
  - state=IDLE.
  - pmem_read=0, pmem_write=0, pmem_address=0, pmem_wdata=0.
  - i_pmem_resp=0, d_pmem_resp=0.
  - starve_cnt=0.
- States:
  - IDLE: no grant.
  - SERVE_I: I-cache granted.
  - SERVE_D: D-cache granted.
- IDLE decision (evaluated every cycle):
  - d_req = d_pmem_read | d_pmem_write.
  - If i_pmem_read and (!d_req or starve_cnt==STARVE_LIMIT) -> SERVE_I.
  - Else if d_req -> SERVE_D.
  - Else stay in IDLE.
- Grant latch: on the transition edge, the granted requester's address, write data and read/write strobe are latched into registered pmem_* outputs. Memory sees the request the cycle after the grant decision; minimum latency request->pmem strobe is 1 cycle.
- Read/write conflict: d_pmem_read and d_pmem_write both high is illegal. The arbiter latches write (write wins) and asserts no read.
- Hold: while in SERVE_x, pmem_* hold their latched values regardless of requester input changes.
- Completion:
  - In SERVE_x with pmem_resp=1, x_pmem_resp=1 combinationally in the same cycle and x_pmem_rdata=pmem_rdata.
  - Next edge: state->IDLE, pmem_read/pmem_write cleared.
  - Total: one idle cycle between back-to-back transactions.
- Non-granted requester: resp stays 0. Both rdata outputs may always carry pmem_rdata; only resp qualifies them.
- pmem_resp while in IDLE: ignored, no resp forwarded.
- starve_cnt (4 bits):
  - Increments on every SERVE_D grant made while i_pmem_read=1.
  - Clears on any SERVE_I grant.
  - Saturates at STARVE_LIMIT.
- Requester contract: deassert or change the request in the cycle after its resp. The arbiter re-samples only in IDLE.
- Reset mid-transaction: next edge forces IDLE, strobes dropped, pending pmem_resp ignored.

Optional Feature:
- Macro: ARB_PERF_CNT_EN.
- Defined: three extra output ports.
  - i_grant_count, 32 bits: +1 per SERVE_I grant.
  - d_grant_count, 32 bits: +1 per SERVE_D grant.
  - conflict_count, 32 bits: +1 per IDLE cycle where i_pmem_read and d_req are both high and a grant is issued.
  - All three wrap modulo 2^32 and are cleared by reset.
- Undefined: ports and counters absent; core behaviour identical.

Test Plan:
- Lone I read: i_pmem_read=1, address 0x1230, pmem_resp after 3 cycles with rdata=0xA5..A5 -> pmem_read=1 and pmem_address=0x1230 one cycle after request; i_pmem_resp=1 with rdata 0xA5..A5 in the pmem_resp cycle; pmem_read=0 the next cycle.
- Simultaneous I read 0x0040 and D write 0x8000 with wdata 0x1111..: D served first (pmem_write=1, pmem_wdata 0x1111..), then I served after one IDLE cycle; d_pmem_resp never asserts during the I transaction.
- Starvation: I held high while D issues 5 back-to-back reads, STARVE_LIMIT=4 -> grant order D,D,D,D,I,D; starve_cnt returns to 0 after the I grant.
- Hold stability: change d_pmem_address from 0x2000 to 0x3000 mid SERVE_D -> pmem_address stays 0x2000 until resp.
- Reset during SERVE_I, then pmem_resp=1 arrives -> state IDLE, pmem_read=0, i_pmem_resp=0.
- ARB_PERF_CNT_EN: run the 5-D/1-I starvation sequence -> d_grant_count=5, i_grant_count=1, conflict_count=5.

Source files
------------

// File: rtl/pmem_arbiter_if.sv
// Bus bundle between the two L1 miss ports, the arbiter and the shared pmem line port.
// master: caches + memory side; slave: the arbiter.
interface pmem_arbiter_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int LINE_WIDTH = 128
);
    logic                  i_pmem_read;
    logic [ADDR_WIDTH-1:0] i_pmem_address;
    logic [LINE_WIDTH-1:0] i_pmem_rdata;
    logic                  i_pmem_resp;

    logic                  d_pmem_read;
    logic                  d_pmem_write;
    logic [ADDR_WIDTH-1:0] d_pmem_address;
    logic [LINE_WIDTH-1:0] d_pmem_wdata;
    logic [LINE_WIDTH-1:0] d_pmem_rdata;
    logic                  d_pmem_resp;

    logic                  pmem_read;
    logic                  pmem_write;
    logic [ADDR_WIDTH-1:0] pmem_address;
    logic [LINE_WIDTH-1:0] pmem_wdata;
    logic [LINE_WIDTH-1:0] pmem_rdata;
    logic                  pmem_resp;

    modport slave (
        input  i_pmem_read, i_pmem_address,
        output i_pmem_rdata, i_pmem_resp,
        input  d_pmem_read, d_pmem_write, d_pmem_address, d_pmem_wdata,
        output d_pmem_rdata, d_pmem_resp,
        output pmem_read, pmem_write, pmem_address, pmem_wdata,
        input  pmem_rdata, pmem_resp
    );

    modport master (
        output i_pmem_read, i_pmem_address,
        input  i_pmem_rdata, i_pmem_resp,
        output d_pmem_read, d_pmem_write, d_pmem_address, d_pmem_wdata,
        input  d_pmem_rdata, d_pmem_resp,
        input  pmem_read, pmem_write, pmem_address, pmem_wdata,
        output pmem_rdata, pmem_resp
    );
endinterface

// File: rtl/pmem_arbiter.sv
// I/D miss-port arbiter for the shared pmem line port; D has priority, starvation limit protects I.
// Optional grant/conflict counters are enabled with `define ARB_PERF_CNT_EN.
module pmem_arbiter #(
    parameter int ADDR_WIDTH   = 16,
    parameter int LINE_WIDTH   = 128,
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic reset,
    pmem_arbiter_if.slave bus
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [31:0] i_grant_count,
    output logic [31:0] d_grant_count,
    output logic [31:0] conflict_count
`endif
);
    typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_t;

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    state_t     state;
    state_t     state_next;
    logic       d_req;
    logic       grant_i;
    logic       grant_d;
    logic [3:0] starve_cnt;

    always_comb begin
        d_req   = bus.d_pmem_read | bus.d_pmem_write;
        grant_i = (state == IDLE) && bus.i_pmem_read && (!d_req || starve_cnt == STARVE_MAX);
        grant_d = (state == IDLE) && !grant_i && d_req;
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (grant_i)      state_next = SERVE_I;
                else if (grant_d) state_next = SERVE_D;
            end
            SERVE_I, SERVE_D: begin
                if (bus.pmem_resp) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Response is combinational on pmem_resp; rdata is broadcast and qualified only by resp.
    always_comb begin
        bus.i_pmem_resp  = (state == SERVE_I) && bus.pmem_resp;
        bus.d_pmem_resp  = (state == SERVE_D) && bus.pmem_resp;
        bus.i_pmem_rdata = bus.pmem_rdata;
        bus.d_pmem_rdata = bus.pmem_rdata;
    end

    // Request is latched on the grant edge and held until completion; an illegal
    // simultaneous read+write from D is issued as a write only.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.pmem_read    <= 1'b0;
            bus.pmem_write   <= 1'b0;
            bus.pmem_address <= '0;
            bus.pmem_wdata   <= '0;
        end else if (grant_i) begin
            bus.pmem_read    <= 1'b1;
            bus.pmem_write   <= 1'b0;
            bus.pmem_address <= bus.i_pmem_address;
            bus.pmem_wdata   <= '0;
        end else if (grant_d) begin
            bus.pmem_read    <= bus.d_pmem_read & ~bus.d_pmem_write;
            bus.pmem_write   <= bus.d_pmem_write;
            bus.pmem_address <= bus.d_pmem_address;
            bus.pmem_wdata   <= bus.d_pmem_wdata;
        end else if (state != IDLE && bus.pmem_resp) begin
            bus.pmem_read    <= 1'b0;
            bus.pmem_write   <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            starve_cnt <= '0;
        else if (grant_i)
            starve_cnt <= '0;
        else if (grant_d && bus.i_pmem_read && starve_cnt != STARVE_MAX)
            starve_cnt <= starve_cnt + 4'd1;
    end

`ifdef ARB_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            i_grant_count  <= '0;
            d_grant_count  <= '0;
            conflict_count <= '0;
        end else begin
            if (grant_i) i_grant_count <= i_grant_count + 32'd1;
            if (grant_d) d_grant_count <= d_grant_count + 32'd1;
            if ((grant_i || grant_d) && bus.i_pmem_read && d_req)
                conflict_count <= conflict_count + 32'd1;
        end
    end
`endif
endmodule
